// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [511:0] msg_block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last
);

  typedef enum logic [1:0] {
    LOAD,
    EMIT,
    TAIL
  } state_t;

  state_t      r_state;
  logic [31:0] r_buf [16];
  logic [3:0]  r_wptr;
  logic [63:0] r_len;
  logic        r_first;
  logic        r_last;
  logic        r_tail;
  logic        r_tail80;

  logic        w_acc;
  logic        w_xfer;
  logic [2:0]  w_nb;
  logic [63:0] w_len_fin;
  logic [4:0]  w_wp;
  logic [4:0]  w_wp1;
  logic [4:0]  w_p;
  logic [31:0] w_word;
  logic [31:0] w_fin [16];

  assign in_ready    = (r_state == LOAD);
  assign block_valid = (r_state != LOAD);
  assign block_first = r_first;
  assign block_last  = r_last;
  assign w_acc       = in_valid & in_ready;
  assign w_xfer      = block_valid & block_ready;

  // Final-word buffer image: masked data, 0x80 marker, zero fill, length.
  always_comb begin
    w_nb      = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    w_len_fin = r_len + {58'd0, w_nb, 3'd0};
    w_wp      = {1'b0, r_wptr};
    w_wp1     = w_wp + 5'd1;
    w_p       = w_wp1 + {4'd0, (w_nb == 3'd4)};
    unique case (w_nb)
      3'd0:    w_word = 32'h8000_0000;
      3'd1:    w_word = {in_word[31:24], 24'h80_0000};
      3'd2:    w_word = {in_word[31:16], 16'h8000};
      3'd3:    w_word = {in_word[31:8], 8'h80};
      default: w_word = in_word;
    endcase
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < w_wp)
        w_fin[i] = r_buf[i];
      else if (5'(i) == w_wp)
        w_fin[i] = w_word;
      else if (5'(i) == w_wp1 && w_nb == 3'd4)
        w_fin[i] = 32'h8000_0000;
      else
        w_fin[i] = 32'h0;
    end
    if (w_p <= 5'd14) begin
      w_fin[14] = w_len_fin[63:32];
      w_fin[15] = w_len_fin[31:0];
    end
  end

  // Flatten the buffer, word 0 in the top bits.
  always_comb begin
    msg_block = '0;
    for (int i = 0; i < 16; i++)
      msg_block[511-32*i -: 32] = r_buf[i];
  end

  // Control FSM, buffer fill and length tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= LOAD;
      r_wptr   <= 4'd0;
      r_len    <= 64'd0;
      r_first  <= 1'b1;
      r_last   <= 1'b0;
      r_tail   <= 1'b0;
      r_tail80 <= 1'b0;
      for (int i = 0; i < 16; i++)
        r_buf[i] <= 32'h0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (w_acc) begin
            if (in_last) begin
              for (int i = 0; i < 16; i++)
                r_buf[i] <= w_fin[i];
              r_wptr   <= 4'd0;
              r_len    <= w_len_fin;
              r_last   <= (w_p <= 5'd14);
              r_tail   <= (w_p >= 5'd15);
              r_tail80 <= (w_p == 5'd17);
              r_state  <= EMIT;
            end else begin
              r_buf[r_wptr] <= in_word;
              r_wptr        <= r_wptr + 4'd1;
              r_len         <= r_len + 64'd32;
              if (r_wptr == 4'd15) begin
                r_last  <= 1'b0;
                r_tail  <= 1'b0;
                r_state <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (w_xfer) begin
            r_first <= r_last;
            if (r_tail) begin
              r_buf[0] <= r_tail80 ? 32'h8000_0000 : 32'h0;
              for (int i = 1; i < 14; i++)
                r_buf[i] <= 32'h0;
              r_buf[14] <= r_len[63:32];
              r_buf[15] <= r_len[31:0];
              r_last    <= 1'b1;
              r_tail    <= 1'b0;
              r_state   <= TAIL;
            end else begin
              if (r_last) begin
                r_len  <= 64'd0;
                r_last <= 1'b0;
              end
              r_state <= LOAD;
            end
          end
        end
        TAIL: begin
          if (w_xfer) begin
            r_len   <= 64'd0;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_state <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: directed vectors plus random
// messages checked against a byte-level SHA-256 padding model.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] msg_block;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;

  int           vec;
  int           errs;
  logic [31:0]  words[$];
  int           lastb;
  logic [511:0] exp_q[$];
  bit           rnd_gap;
  bit           rnd_rdy;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk(clk),
    .reset(reset),
    .in_word(in_word),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .in_bytes(in_bytes),
    .msg_block(msg_block),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .block_first(block_first),
    .block_last(block_last)
  );

  task automatic gen_msg(input int nfull, input int lb);
    words.delete();
    for (int i = 0; i <= nfull; i++)
      words.push_back($urandom);
    lastb = lb;
  endtask

  // Standard SHA-256 padding over the message bytes.
  task automatic build_expected();
    byte unsigned     b[$];
    longint unsigned  bits;
    logic [511:0]     blk;
    int               nb;
    int               k;
    nb = (lastb > 4) ? 4 : lastb;
    for (int i = 0; i < words.size(); i++) begin
      k = (i == words.size() - 1) ? nb : 4;
      for (int j = 0; j < k; j++)
        b.push_back(words[i][31-8*j -: 8]);
    end
    bits = 64'(b.size()) * 8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56)
      b.push_back(8'h00);
    for (int j = 7; j >= 0; j--)
      b.push_back(bits[8*j +: 8]);
    exp_q.delete();
    for (int m = 0; m < b.size() / 64; m++) begin
      for (int j = 0; j < 64; j++)
        blk[511-8*j -: 8] = b[64*m+j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic drive_msg();
    int n;
    int i;
    int guard;
    n = words.size();
    i = 0;
    guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_word  = $urandom;
        in_last  = 1'($urandom);
        continue;
      end
      in_valid = 1'b1;
      in_word  = words[i];
      in_last  = (i == n - 1);
      in_bytes = (i == n - 1) ? 3'(lastb) : 3'($urandom);
      if (in_ready) i++;
    end
    if (i < n) begin
      vec++;
      errs++;
      $display("FAIL drive_timeout: accepted %0d words, required %0d", i, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_msg();
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < exp_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      block_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (block_valid && block_ready) begin
        vec++;
        if (msg_block !== exp_q[idx]) begin
          errs++;
          $display("FAIL block%0d_data: got %h required %h", idx, msg_block, exp_q[idx]);
        end
        vec++;
        if (block_first !== (idx == 0)) begin
          errs++;
          $display("FAIL block%0d_first: got %b required %b", idx, block_first, idx == 0);
        end
        vec++;
        if (block_last !== (idx == exp_q.size() - 1)) begin
          errs++;
          $display("FAIL block%0d_last: got %b required %b", idx, block_last, idx == exp_q.size() - 1);
        end
        idx++;
      end
    end
    if (idx < exp_q.size()) begin
      vec++;
      errs++;
      $display("FAIL recv_timeout: got %0d blocks, required %0d", idx, exp_q.size());
    end
  endtask

  task automatic run_msg();
    build_expected();
    fork
      drive_msg();
      recv_msg();
    join
    block_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (block_valid !== 1'b0) begin
        errs++;
        $display("FAIL idle_valid: got %b required 0", block_valid);
      end
    end
    block_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_bytes    = 3'd0;
    in_word     = 32'h0;
    block_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if (in_ready !== 1'b1 || block_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_hs: ready=%b valid=%b required 1/0", in_ready, block_valid);
    end
    vec++;
    if (msg_block !== 512'd0) begin
      errs++;
      $display("FAIL reset_block: got %h required 0", msg_block);
    end
    vec++;
    if (block_first !== 1'b1 || block_last !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: first=%b last=%b required 1/0", block_first, block_last);
    end
  endtask

  task automatic test_single(input logic [31:0] w, input logic [2:0] nb,
                             input logic [511:0] e, input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = 1'b1;
    in_bytes = nb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vec++;
    if (block_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s_latency: valid=%b required 1", nm, block_valid);
    end
    vec++;
    if (msg_block !== e) begin
      errs++;
      $display("FAIL %s_data: got %h required %h", nm, msg_block, e);
    end
    vec++;
    if (block_first !== 1'b1 || block_last !== 1'b1) begin
      errs++;
      $display("FAIL %s_flags: first=%b last=%b required 1/1", nm, block_first, block_last);
    end
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    vec++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s_done: valid=%b ready=%b required 0/1", nm, block_valid, in_ready);
    end
  endtask

  task automatic test_abc();
    logic [511:0] e;
    e = '0;
    e[511:480] = 32'h6162_6380;
    e[31:0]    = 32'h0000_0018;
    test_single(32'h6162_6300, 3'd3, e, "abc");
  endtask

  task automatic test_empty();
    logic [511:0] e;
    e = '0;
    e[511:480] = 32'h8000_0000;
    test_single($urandom, 3'd0, e, "empty");
  endtask

  task automatic test_boundaries();
    rnd_gap = 1'b0;
    rnd_rdy = 1'b0;
    gen_msg(13, 4);
    run_msg();
    gen_msg(15, 4);
    run_msg();
    gen_msg(14, 3);
    run_msg();
    gen_msg(15, 0);
    run_msg();
  endtask

  task automatic test_random();
    rnd_gap = 1'b1;
    rnd_rdy = 1'b1;
    for (int m = 0; m < 10; m++) begin
      gen_msg($urandom_range(0, 40), $urandom_range(0, 7));
      run_msg();
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] snap;
    logic         sf;
    logic         sl;
    rnd_gap = 1'b0;
    block_ready = 1'b0;
    gen_msg(15, 4);
    build_expected();
    drive_msg();
    snap = msg_block;
    sf   = block_first;
    sl   = block_last;
    repeat (5) begin
      @(negedge clk);
      vec++;
      if (block_valid !== 1'b1 || in_ready !== 1'b0 || msg_block !== snap ||
          block_first !== sf || block_last !== sl) begin
        errs++;
        $display("FAIL bp_hold: valid=%b ready=%b first=%b last=%b required stable 1/0/%b/%b",
                 block_valid, in_ready, block_first, block_last, sf, sl);
      end
    end
    @(negedge clk);
    block_ready = 1'b1;
    vec++;
    if (msg_block !== exp_q[0] || block_last !== 1'b0) begin
      errs++;
      $display("FAIL bp_block1: got %h last=%b required %h last=0", msg_block, block_last, exp_q[0]);
    end
    @(negedge clk);
    block_ready = 1'b0;
    vec++;
    if (block_valid !== 1'b1 || msg_block !== exp_q[1] || block_last !== 1'b1 || block_first !== 1'b0) begin
      errs++;
      $display("FAIL bp_tail: valid=%b last=%b first=%b got %h required %h",
               block_valid, block_last, block_first, msg_block, exp_q[1]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_reset: valid=%b ready=%b required 0/1", block_valid, in_ready);
    end
    rnd_rdy = 1'b0;
    words.delete();
    words.push_back(32'h6162_6300);
    lastb = 3;
    run_msg();
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rnd_gap = 1'b0;
    rnd_rdy = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_boundaries();
    test_random();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
